// File: rtl/sonic_gearbox_tx_xg_if.sv
// Block/word handshake bundle for the 66:40 transmit gearbox.
// master drives blocks in and consumes words; slave is the gearbox itself.
interface sonic_gearbox_tx_xg_if #(
  parameter int IN_W  = 66,
  parameter int OUT_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  data_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/sonic_gearbox_tx_xg.sv
// 66:40 transmit gearbox: words appear one cycle after the filling block; out_ready low holds the word and stalls input at fill >= OUT_W.
// Optional sync-header error counter under SONIC_GEARBOX_TX_SH_CHECK_EN.
module sonic_gearbox_tx_xg #(
  parameter int IN_W   = 66,
  parameter int OUT_W  = 40,
  parameter int FILL_W = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  sonic_gearbox_tx_xg_if.slave bus,
  output logic [FILL_W-1:0]   fill_level,
  output logic [15:0]         sh_err_cnt
);
  localparam int BUF_W = IN_W + OUT_W;
  localparam logic [FILL_W-1:0] IN_F   = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] OUT_F  = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] OUT2_F = FILL_W'(2 * OUT_W);

  logic [BUF_W-1:0]  buf_q, buf_n, buf_e;
  logic [FILL_W-1:0] fill_q, fill_n, fill_e;
  logic              emit, accept;

  assign bus.out_valid = (fill_q >= OUT_F);
  assign bus.data_out  = buf_q[OUT_W-1:0];
  // out_ready feeds in_ready combinationally so a full drain and refill can share a cycle.
  assign bus.in_ready  = reset_n && ((fill_q < OUT_F) || (bus.out_ready && (fill_q < OUT2_F)));
  assign emit          = bus.out_valid && bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign fill_level    = fill_q;

  always_comb begin
    buf_e  = buf_q;
    fill_e = fill_q;
    if (emit) begin
      buf_e  = buf_q >> OUT_W;
      fill_e = fill_q - OUT_F;
    end
    buf_n  = buf_e;
    fill_n = fill_e;
    if (accept) begin
      buf_n  = (buf_e & ~({BUF_W{1'b1}} << fill_e)) | (BUF_W'(bus.data_in) << fill_e);
      fill_n = fill_e + IN_F;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_n;
      fill_q <= fill_n;
    end
  end

`ifdef SONIC_GEARBOX_TX_SH_CHECK_EN
  logic [15:0] sh_err_q;
  logic        sh_bad;

  // Valid headers are 01 (data) and 10 (control); the block goes out untouched either way.
  assign sh_bad = (bus.data_in[1:0] == 2'b00) || (bus.data_in[1:0] == 2'b11);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_err_q <= '0;
    end else if (accept && sh_bad && (sh_err_q != 16'hFFFF)) begin
      sh_err_q <= sh_err_q + 16'd1;
    end
  end

  assign sh_err_cnt = sh_err_q;
`else
  assign sh_err_cnt = '0;
`endif
endmodule

// File: tb/tb_sonic_gearbox_tx_xg.sv
// Scoreboarded bench for the 66:40 transmit gearbox: accepted blocks feed a bit queue, a monitor checks every emitted word.
module tb_sonic_gearbox_tx_xg;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  fill_level;
  logic [15:0] sh_err_cnt;

  sonic_gearbox_tx_xg_if bus_if ();

  sonic_gearbox_tx_xg dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .fill_level (fill_level),
    .sh_err_cnt (sh_err_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_words = 0;
  bit          bitq[$];
  logic [39:0] cap[$];
  logic [39:0] exp_word;
  logic [31:0] hi, lo;
  logic [15:0] exp_sh;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_bits(input logic [65:0] d);
    for (int k = 0; k < 66; k++) bitq.push_back(d[k]);
  endtask

  // Presents a block until the gearbox takes it; returns just after the accepting edge.
  task automatic send(input logic [65:0] d);
    bit done;
    done = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.data_in  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        push_bits(d);
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 66'd0, 66'd1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.data_in  = '0;
    @(negedge clk);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_data_out", bus_if.data_out, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_in_ready", bus_if.in_ready, 0);
    chk("rst_sh_err", sh_err_cnt, 0);
    bitq.delete();
    cap.delete();
    n_words = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every emitted word must equal the next 40 accepted bits, earliest at bit 0.
  always @(negedge clk) begin
    if (reset_n && bus_if.out_valid && bus_if.out_ready) begin
      n_words++;
      cap.push_back(bus_if.data_out);
      if (bitq.size() < 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL word_underflow: got word %0h with only %0d expected bits queued", bus_if.data_out, bitq.size());
      end else begin
        exp_word = '0;
        for (int k = 0; k < 40; k++) exp_word[k] = bitq.pop_front();
        chk("word", bus_if.data_out, exp_word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.data_in   = '0;
    bus_if.out_ready = 1'b1;

    // Single block after reset
    do_reset();
    send(66'h1);
    @(negedge clk);
    chk("t1_out_valid", bus_if.out_valid, 1);
    chk("t1_data_out", bus_if.data_out, 40'h00_0000_0001);
    chk("t1_fill66", fill_level, 66);
    idle(1);
    @(negedge clk);
    chk("t1_fill26", fill_level, 26);
    chk("t1_out_valid0", bus_if.out_valid, 0);

    // Line rate: 20 blocks -> 33 words
    do_reset();
    for (int i = 0; i < 20; i++) begin
      hi = 32'hA5A5_0000 + 32'(i);
      lo = 32'h1234_5678 ^ (32'(i) * 32'h0101_0101);
      send({hi, lo, 2'b01});
    end
    idle(6);
    @(negedge clk);
    chk("t2_words", 66'(n_words), 33);
    chk("t2_fill", fill_level, 0);
    chk("t2_out_valid", bus_if.out_valid, 0);
    chk("t2_bits_left", 66'(bitq.size()), 0);

    // Straddle: ones then zeros
    do_reset();
    send({66{1'b1}});
    send(66'h0);
    idle(4);
    @(negedge clk);
    chk("t3_words", 66'(n_words), 3);
    if (cap.size() >= 2) begin
      chk("t3_word1", cap[0], 40'hFF_FFFF_FFFF);
      chk("t3_word2", cap[1], 40'h00_03FF_FFFF);
    end else begin
      chk("t3_word_count", 66'(cap.size()), 3);
    end
    chk("t3_fill", fill_level, 12);

    // Backpressure at fill 66
    do_reset();
    bus_if.out_ready = 1'b0;
    send(66'h1_2345_6789_ABCD_EF01);
    bus_if.in_valid = 1'b1;
    bus_if.data_in  = 66'h2_0F0F_0F0F_F0F0_F0F1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data", bus_if.data_out, 40'h89_ABCD_EF01);
      chk("t4_hold_valid", bus_if.out_valid, 1);
      chk("t4_hold_in_ready", bus_if.in_ready, 0);
      chk("t4_hold_fill", fill_level, 66);
      @(posedge clk);
      #1;
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_in_ready", bus_if.in_ready, 1);
    push_bits(bus_if.data_in);
    @(posedge clk);
    #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    chk("t4_fill92", fill_level, 92);

    // Mid-stream asynchronous reset at fill 92
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_out_valid", bus_if.out_valid, 0);
    chk("t5_data_out", bus_if.data_out, 0);
    chk("t5_fill", fill_level, 0);
    bitq.delete();
    cap.delete();
    n_words = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus_if.out_ready = 1'b1;
    send(66'h2);
    @(negedge clk);
    chk("t5_first_word", bus_if.data_out, 40'h00_0000_0002);
    chk("t5_valid", bus_if.out_valid, 1);

    // Sync-header check
    do_reset();
    send({64'h0123_4567_89AB_CDEF, 2'b00});
    send({64'hFEDC_BA98_7654_3210, 2'b11});
    send({64'h0F0F_0F0F_0F0F_0F0F, 2'b01});
    send({64'hF0F0_F0F0_F0F0_F0F0, 2'b10});
    idle(6);
    @(negedge clk);
`ifdef SONIC_GEARBOX_TX_SH_CHECK_EN
    exp_sh = 16'd2;
`else
    exp_sh = 16'd0;
`endif
    chk("t6_sh_err_cnt", sh_err_cnt, exp_sh);
    chk("t6_words", 66'(n_words), 6);
    chk("t6_fill", fill_level, 24);
    chk("t6_bits_left", 66'(bitq.size()), 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
